// File: rtl/pipe_pkg.sv
// Shared constants for the MIPS pipeline-stage registers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: default datapath width, per-stage reset values (a NOP so a
// freshly reset stage injects a harmless instruction), and an occupancy helper.
package pipe_pkg;

  localparam int PIPE_W = 32;

  // sll $0,$0,0 encodes as all zeros: the canonical MIPS NOP.
  localparam logic [PIPE_W-1:0] IFID_RESET_VAL  = 32'h0000_0000;
  localparam logic [PIPE_W-1:0] IDEX_RESET_VAL  = 32'h0000_0000;
  localparam logic [PIPE_W-1:0] EXMEM_RESET_VAL = 32'h0000_0000;
  localparam logic [PIPE_W-1:0] MEMWB_RESET_VAL = 32'h0000_0000;

  // Number of held entries from the two valid bits (0, 1 or 2).
  function automatic logic [1:0] occupancy(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_reg_skid_reg_en.sv
// Data register with load enable and synchronous active-low reset.
// Latency: 1 cycle from en to q.
// Backpressure: none; the parent decides when to load.
//
// Ports: clk, reset (sync, active-low, loads RESET_VAL), en (load strobe),
//        d (next value), q (registered value, held while en==0).
module reg_en #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_reg_skid.sv
// Pipeline-stage register with a 2-entry skid buffer and local flush.
// Latency: 1 cycle in_fire -> out_valid; 1 entry/cycle with out_ready high.
// Backpressure: in_ready = ~skid_valid (registered only, no out_ready path).
//
// Ports: clk, reset (sync, active-low), flush (squash all held entries),
//        in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data
//        (downstream head entry), count (entries held, 0..2).
module pipe_reg_skid
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = PIPE_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;

  logic             in_fire;
  logic             out_fire;
  logic             main_free;
  logic             main_en;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;

  // Ready depends only on registered state, so out_ready never ripples
  // upstream; the skid slot absorbs the one in-flight beat instead.
  assign in_ready  = reset & ~skid_valid;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign main_free = ~out_valid | out_fire;

  // Main takes the older skid entry first to keep FIFO order.
  assign main_d    = skid_valid ? skid_data : in_data;
  assign main_en   = ~flush & main_free & (skid_valid | in_fire);

  // Skid captures input when main cannot, or when main is being refilled
  // from skid in the same cycle.
  assign skid_en   = ~flush & in_fire & (skid_valid | ~main_free);

  reg_en #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk   (clk),
    .reset (reset),
    .en    (main_en),
    .d     (main_d),
    .q     (out_data)
  );

  reg_en #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (skid_en),
    .d     (in_data),
    .q     (skid_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      // Data registers keep their contents; only the valid bits drop.
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      out_valid  <= skid_valid | in_fire;
      skid_valid <= skid_valid & in_fire;
    end else begin
      skid_valid <= skid_valid | in_fire;
    end
  end

  assign count = occupancy(out_valid, skid_valid);

endmodule

// File: tb/tb_pipe_reg_skid.sv
module tb_pipe_reg_skid;

  localparam int          W  = 32;
  localparam logic [W-1:0] RV = 32'h5A5A_0013;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic [1:0]   count;

  int checks = 0;
  int errors = 0;

  // Reference model: a bounded FIFO of up to two entries plus the last
  // value shown on the output.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_out;

  pipe_reg_skid #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Advance one clock, updating the model from the inputs presented before
  // the edge; returns 1 ns after the edge.
  task automatic tick();
    bit inf, outf;
    if (!reset) begin
      mq.delete();
      m_out = RV;
    end else if (flush) begin
      mq.delete();
    end else begin
      outf = (mq.size() > 0) && out_ready;
      inf  = in_valid && (mq.size() < 2);
      if (outf) void'(mq.pop_front());
      if (inf) mq.push_back(in_data);
      if (mq.size() > 0) m_out = mq[0];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
  endtask

  task automatic drain();
    idle_inputs();
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || count !== 2'd0 || out_data !== RV || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: out_valid=%b count=%0d out_data=%h in_ready=%b, want 0 0 %h 0",
                 c, out_valid, count, out_data, in_ready, RV);
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release in_ready=%b want 1", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || count !== 2'd0 || out_data !== RV || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_after: out_valid=%b count=%0d out_data=%h in_ready=%b, want 0 0 %h 1",
               out_valid, count, out_data, in_ready, RV);
    end
  endtask

  task automatic test_streaming();
    idle_inputs();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready beat%0d in_ready=%b want 1", i, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== W'(i) || count > 2'd1 || out_data !== m_out) begin
        errors++;
        $display("FAIL stream_data beat%0d out_valid=%b out_data=%h count=%0d want 1 %h <=1",
                 i, out_valid, out_data, count, W'(i));
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || count !== 2'd0 || out_data !== 32'h0000_0008) begin
      errors++;
      $display("FAIL stream_end out_valid=%b count=%0d out_data=%h want 0 0 00000008",
               out_valid, count, out_data);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] vals[3];
    logic [W-1:0] got[$];
    int           idx;
    vals[0] = 32'hAAAA_0001; vals[1] = 32'hAAAA_0002; vals[2] = 32'hAAAA_0003;
    idle_inputs();
    idx = 0;
    // Upstream holds each value until it is accepted.
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_data  = vals[idx];
      if (in_ready === 1'b1) idx++;
      tick();
    end
    checks++;
    if (count !== 2'd2 || in_ready !== 1'b0 || idx !== 2) begin
      errors++;
      $display("FAIL bp_full count=%0d in_ready=%b accepted=%0d want 2 0 2", count, in_ready, idx);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 8 && got.size() < 3; c++) begin
      if (idx < 3) begin
        in_valid = 1'b1;
        in_data  = vals[idx];
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid === 1'b1) got.push_back(out_data);
      if (idx < 3 && in_ready === 1'b1) idx++;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL bp_drain_count got=%0d want 3", got.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got[k] !== vals[k]) begin
          errors++;
          $display("FAIL bp_order idx%0d got=%h want %h", k, got[k], vals[k]);
        end
      end
    end
    drain();
  endtask

  task automatic test_simultaneous();
    idle_inputs();
    in_valid = 1'b1; in_data = 32'h1111_1111;
    tick();
    checks++;
    if (count !== 2'd1 || out_data !== 32'h1111_1111) begin
      errors++;
      $display("FAIL sim_setup count=%0d out_data=%h want 1 11111111", count, out_data);
    end
    in_data = 32'h2222_2222; out_ready = 1'b1;
    tick();
    checks++;
    if (count !== 2'd1 || out_valid !== 1'b1 || out_data !== 32'h2222_2222) begin
      errors++;
      $display("FAIL sim_swap count=%0d out_valid=%b out_data=%h want 1 1 22222222",
               count, out_valid, out_data);
    end
    drain();
  endtask

  task automatic fill_two(input logic [W-1:0] a, input logic [W-1:0] b);
    idle_inputs();
    in_valid = 1'b1; in_data = a;
    tick();
    in_data = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    bit seen;
    fill_two(32'h3333_0001, 32'h3333_0002);
    checks++;
    if (count !== 2'd2) begin
      errors++;
      $display("FAIL flush_setup count=%0d want 2", count);
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h3333_0001) begin
      errors++;
      $display("FAIL flush_clear count=%0d out_valid=%b in_ready=%b out_data=%h want 0 0 1 33330001",
               count, out_valid, in_ready, out_data);
    end
    idle_inputs();
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      tick();
      if (out_valid === 1'b1 || out_data === 32'hDEAD_BEEF) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL flush_leak out_valid=%b out_data=%h want squashed entry never shown",
               out_valid, out_data);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_priority();
    fill_two(32'h4444_0001, 32'h4444_0002);
    reset = 1'b0; flush = 1'b1;
    tick();
    checks++;
    if (out_data !== RV || count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_prio out_data=%h count=%0d out_valid=%b in_ready=%b want %h 0 0 0",
               out_data, count, out_valid, in_ready, RV);
    end
    reset = 1'b1; flush = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_prio_release in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_random();
    idle_inputs();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      checks++;
      if (in_ready !== (mq.size() < 2)) begin
        errors++;
        $display("FAIL rand_ready cyc%0d in_ready=%b want %b", c, in_ready, mq.size() < 2);
      end
      tick();
      checks++;
      if (out_valid !== (mq.size() > 0) || int'(count) != mq.size() || out_data !== m_out) begin
        errors++;
        $display("FAIL rand_state cyc%0d out_valid=%b count=%0d out_data=%h want %b %0d %h",
                 c, out_valid, count, out_data, mq.size() > 0, mq.size(), m_out);
      end
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    mq.delete();
    m_out = RV;
    #2;
    test_reset();
    test_streaming();
    test_backpressure();
    test_simultaneous();
    test_flush();
    test_reset_priority();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_reg_skid.md
Name: pipe_reg_skid

Overview:
- Parametrised pipeline-stage register; successor to the fixed 32-bit, always-loading datapath register.
- Adds configurable width and reset value, a valid/ready handshake, a 2-entry skid buffer for full throughput under backpressure, and a pipeline flush.
- Sits between MIPS pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) so stalls and branch flushes are handled locally, not by global clock gating.

Parameters:
- WIDTH, 32, data bits per entry.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into out_data and the skid data register on reset.

Ports:
- clk  input  1  on-board clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- flush  input  1  discard all held entries (branch/exception squash).
- in_valid  input  1  upstream presents data.
- in_data  input  WIDTH  upstream data.
- in_ready  output  1  stage can accept; a transfer occurs when in_valid & in_ready.
- out_valid  output  1  out_data holds a valid entry.
- out_data  output  WIDTH  current head entry.
- out_ready  input  1  downstream accepts; a transfer occurs when out_valid & out_ready.
- count  output  2  entries held: 0, 1 or 2.

Behaviour:
- Storage: main register (out_data, out_valid) and skid register (skid_data, skid_valid). Both are reset by reset only; there is no asynchronous path.
- Reset (reset==0 at an edge): out_valid=0, skid_valid=0, out_data=RESET_VAL, skid_data=RESET_VAL, count=0. in_ready is forced 0 combinationally while reset==0.
- in_ready = ~skid_valid (registered state only). There is no combinational path from out_ready to in_ready.
- Priority per edge: reset > flush > normal operation.
- Flush (reset==1, flush==1):
  - Next state: out_valid=0, skid_valid=0.
  - Data registers hold their values.
  - An input transfer in the same cycle is discarded.
  - Any downstream acceptance in the same cycle is still counted by downstream; the stage does not re-present that entry.
- Normal operation, with in_fire = in_valid & in_ready and out_fire = out_valid & out_ready:
  - Main register free (out_valid==0 or out_fire):
    - If skid_valid: main <= skid. If in_fire also, skid <= in_data; otherwise skid_valid <= 0.
    - Else if in_fire: main <= in_data, out_valid <= 1.
    - Else: out_valid <= 0.
  - Main register occupied and not firing:
    - If in_fire: skid <= in_data, skid_valid <= 1.
    - Main holds.
- Latency: 1 cycle from in_fire to out_valid. Throughput: 1 entry/cycle with out_ready held high.
- Ordering is strictly FIFO; no entry is dropped or duplicated except by flush or reset.
- out_data holds its last value while out_valid==0; it is never zeroed by consumption.
- count = out_valid + skid_valid. count==2 implies in_ready==0.
- Simultaneous in_fire and out_fire with count==1: count stays 1 and the new entry moves to main.
- Reset or flush asserted mid-stream (count==2): count==0 next cycle and in_ready==1 (if reset has been released).

Decomposition:
- Shared package pipe_pkg: default width constant PIPE_W=32, and RESET_VAL defaults for each stage register (e.g. a NOP encoding 32'h0000_0000 for IF/ID).
- One natural sub-module: reg_en, a WIDTH-parametrised register with load enable and synchronous active-low reset to RESET_VAL. Instantiate it twice, once for main data and once for skid data. Valid bits stay in the parent.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release. Required: out_valid=0, count=0, out_data=RESET_VAL, in_ready=0 during reset and 1 on the first cycle after release.
- Streaming: out_ready=1, push 32'h0000_0001..32'h0000_0008 on consecutive cycles. Required: same values on out_data one cycle later, count never exceeds 1, in_ready stays 1.
- Backpressure: push 32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003 with out_ready=0. Required: count reaches 2 and in_ready=0, so the third value is not accepted and is held upstream. After releasing out_ready, output order is 0001, 0002, 0003.
- Simultaneous: with count==1 holding 32'h1111_1111, assert in_valid(32'h2222_2222) and out_ready together. Required: count stays 1 and out_data=32'h2222_2222 next cycle.
- Flush: with count==2, assert flush together with in_valid(32'hDEAD_BEEF). Required: count=0, out_valid=0, in_ready=1 next cycle, and DEAD_BEEF never appears on the output.
- Reset priority: with count==2, assert reset=0 and flush=1 together. Required: out_data=RESET_VAL next cycle (reset wins over flush), count=0.
